// File: rtl/ram_bank_param_pkg.sv
// rtl/ram_bank_param_pkg.sv - shared constants and state encoding for the banked data memory
package ram_bank_param_pkg;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam int   MEM_LAT_MAX  = 2;

  typedef enum logic {
    MEM_ST_CLEAR = 1'b0,
    MEM_ST_IDLE  = 1'b1
  } mem_st_e;

endpackage

// File: rtl/ram_bank_param_if.sv
// rtl/ram_bank_param_if.sv - request/response bus between access stage and data memory
interface ram_bank_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req;
  logic                  we;
  logic [DATA_W/8-1:0]   be;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic                  ready;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;
  logic                  err;
  logic                  busy;

  modport master (
    output req, we, be, addr, wdata,
    input  ready, rvalid, rdata, err, busy
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output ready, rvalid, rdata, err, busy
  );
endinterface

// File: rtl/ram_bank_param_core.sv
// rtl/ram_bank_param_core.sv - storage array with byte-lane write and registered read port
module ram_bank_param_core #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                re,
  input  logic                rclr,
  output logic [DATA_W-1:0]   rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int k = 0; k < DATA_W/8; k++) begin
      if (we && be[k]) begin
        mem[idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  // rdata only moves on a read response, so it holds between responses
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (rclr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end
  end
endmodule

// File: rtl/ram_bank_param.sv
// rtl/ram_bank_param.sv - data memory with zero-fill sequencer, range check and read latency pipe
module ram_bank_param
  import ram_bank_param_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int DEPTH        = 24576,
  parameter int READ_LAT     = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic            clk,
  input  logic            rst,
  ram_bank_param_if.slave bus
);
  localparam int IDX_W = ADDR_W - 2;
  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BE_W  = DATA_W / 8;

  mem_st_e                state;
  logic [CNT_W-1:0]       cnt;
  logic                   ready_q;
  logic                   busy_q;
  logic [MEM_LAT_MAX-1:0] v_pipe;
  logic [MEM_LAT_MAX-1:0] e_pipe;
  logic [IDX_W-1:0]       idx;
  logic                   oor;
  logic                   acc;
  logic                   acc_rd;
  logic                   acc_wr;
  logic                   filling;
  logic                   core_we;
  logic                   core_re;
  logic                   core_rclr;
  logic [CNT_W-1:0]       core_idx;
  logic [BE_W-1:0]        core_be;
  logic [DATA_W-1:0]      core_wdata;
  logic [DATA_W-1:0]      core_rdata;
  logic                   unused_bits;

  assign idx         = bus.addr[ADDR_W-1:2];
  assign unused_bits = ^{bus.addr[1:0], v_pipe, e_pipe};
  assign oor         = idx >= IDX_W'(DEPTH);

  assign acc     = bus.req && ready_q && (rst != RST_ENABLE);
  assign acc_rd  = acc && (bus.we != WRITE_ENABLE);
  assign acc_wr  = acc && (bus.we == WRITE_ENABLE) && !oor;
  assign filling = (state == MEM_ST_CLEAR) && (rst != RST_ENABLE);

  // the fill sequencer owns the write port while ready is low
  assign core_we    = filling || acc_wr;
  assign core_idx   = filling ? cnt : idx[CNT_W-1:0];
  assign core_be    = filling ? '1 : bus.be;
  assign core_wdata = filling ? '0 : bus.wdata;
  assign core_re    = acc_rd && !oor;
  assign core_rclr  = acc_rd && oor;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state   <= (CLEAR_ON_RST != 0) ? MEM_ST_CLEAR : MEM_ST_IDLE;
      cnt     <= '0;
      ready_q <= 1'b0;
      busy_q  <= (CLEAR_ON_RST != 0);
    end else begin
      case (state)
        MEM_ST_CLEAR: begin
          if (cnt == CNT_W'(DEPTH - 1)) begin
            state   <= MEM_ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      v_pipe <= '0;
      e_pipe <= '0;
    end else begin
      v_pipe <= {v_pipe[MEM_LAT_MAX-2:0], acc_rd};
      e_pipe <= {e_pipe[MEM_LAT_MAX-2:0], acc && oor};
    end
  end

  ram_bank_param_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (CNT_W)
  ) u_core (
    .clk   (clk),
    .rst   (rst == RST_ENABLE),
    .we    (core_we),
    .be    (core_be),
    .idx   (core_idx),
    .wdata (core_wdata),
    .re    (core_re),
    .rclr  (core_rclr),
    .rdata (core_rdata)
  );

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] data_q;
      always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
          data_q <= '0;
        end else if (v_pipe[0]) begin
          data_q <= core_rdata;
        end
      end
      assign bus.rdata = data_q;
    end else begin : g_lat1
      assign bus.rdata = core_rdata;
    end
  endgenerate

  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;
  assign bus.rvalid = v_pipe[READ_LAT-1];
  assign bus.err    = e_pipe[READ_LAT-1];
endmodule

// File: tb/tb_ram_bank_param.sv
// tb/tb_ram_bank_param.sv - directed self-checking bench for ram_bank_param at latency 1 and 2
module tb_ram_bank_param;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ram_bank_param_if #(.DATA_W(32), .ADDR_W(32)) b1 ();
  ram_bank_param_if #(.DATA_W(32), .ADDR_W(32)) b2 ();

  ram_bank_param #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(16), .READ_LAT(1), .CLEAR_ON_RST(1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  ram_bank_param #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(16), .READ_LAT(2), .CLEAR_ON_RST(1)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd1(input logic [31:0] a, input logic [31:0] ed, input logic ee, input string tag);
    b1.req  = 1'b1;
    b1.we   = 1'b0;
    b1.addr = a;
    step();
    b1.req = 1'b0;
    chk({tag, "_rvalid"}, b1.rvalid, 1);
    chk({tag, "_data"}, b1.rdata, ed);
    chk({tag, "_err"}, b1.err, ee);
  endtask

  task automatic wr_bus(input int which, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic ee, input string tag);
    if (which == 1) begin
      b1.req = 1'b1; b1.we = 1'b1; b1.addr = a; b1.wdata = d; b1.be = be;
    end else begin
      b2.req = 1'b1; b2.we = 1'b1; b2.addr = a; b2.wdata = d; b2.be = be;
    end
    step();
    b1.req = 1'b0;
    b2.req = 1'b0;
    if (which == 1) begin
      chk({tag, "_rvalid"}, b1.rvalid, 0);
      chk({tag, "_err"}, b1.err, ee);
    end else begin
      chk({tag, "_rvalid"}, b2.rvalid, 0);
      chk({tag, "_err"}, b2.err, ee);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    b1.req = 1'b0; b1.we = 1'b0; b1.be = 4'h0; b1.addr = '0; b1.wdata = '0;
    b2.req = 1'b0; b2.we = 1'b0; b2.be = 4'h0; b2.addr = '0; b2.wdata = '0;
    step();
    step();
    chk("rst_ready", b1.ready, 0);
    chk("rst_busy", b1.busy, 1);
    chk("rst_rvalid", b1.rvalid, 0);
    chk("rst_err", b1.err, 0);
    chk("rst_data", b1.rdata, 32'h0);
    chk("rst_busy2", b2.busy, 1);

    // zero-fill takes DEPTH edges after reset falls
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("fill_busy", b1.busy, 1);
      chk("fill_ready", b1.ready, 0);
    end
    step();
    chk("fill_done_ready", b1.ready, 1);
    chk("fill_done_busy", b1.busy, 0);
    chk("fill_done_ready2", b2.ready, 1);

    for (int i = 0; i < 16; i++) begin
      rd1(32'(i * 4), 32'h0, 1'b0, "zero_rd");
    end

    wr_bus(1, 32'h8, 32'hDEADBEEF, 4'hF, 1'b0, "wr_full");
    rd1(32'h8, 32'hDEADBEEF, 1'b0, "rd_full");
    wr_bus(1, 32'h8, 32'h11223344, 4'b0101, 1'b0, "wr_lane");
    rd1(32'h8, 32'hDE22BE44, 1'b0, "rd_lane");
    step();
    chk("hold_rvalid", b1.rvalid, 0);
    chk("hold_data", b1.rdata, 32'hDE22BE44);
    rd1(32'hB, 32'hDE22BE44, 1'b0, "rd_offset");

    rd1(32'h40, 32'h0, 1'b1, "rd_oor");
    step();
    chk("oor_err_pulse", b1.err, 0);
    wr_bus(1, 32'h44, 32'hCAFEF00D, 4'hF, 1'b1, "wr_oor");
    rd1(32'h8, 32'hDE22BE44, 1'b0, "after_oor_8");
    rd1(32'h0, 32'h0, 1'b0, "after_oor_0");
    rd1(32'h3C, 32'h0, 1'b0, "after_oor_3c");

    // latency-2 instance: back-to-back reads
    wr_bus(2, 32'h0, 32'hA0A0A0A0, 4'hF, 1'b0, "l2_wr0");
    wr_bus(2, 32'h4, 32'hA1A1A1A1, 4'hF, 1'b0, "l2_wr1");
    wr_bus(2, 32'h8, 32'hA2A2A2A2, 4'hF, 1'b0, "l2_wr2");
    b2.req = 1'b1; b2.we = 1'b0; b2.addr = 32'h0;
    step();
    chk("l2_t1_rvalid", b2.rvalid, 0);
    b2.addr = 32'h4;
    step();
    chk("l2_t2_rvalid", b2.rvalid, 1);
    chk("l2_t2_data", b2.rdata, 32'hA0A0A0A0);
    b2.addr = 32'h8;
    step();
    b2.req = 1'b0;
    chk("l2_t3_rvalid", b2.rvalid, 1);
    chk("l2_t3_data", b2.rdata, 32'hA1A1A1A1);
    step();
    chk("l2_t4_rvalid", b2.rvalid, 1);
    chk("l2_t4_data", b2.rdata, 32'hA2A2A2A2);
    step();
    chk("l2_t5_rvalid", b2.rvalid, 0);

    // reset one cycle after an accepted read discards the response
    b2.req = 1'b1; b2.we = 1'b0; b2.addr = 32'h8;
    step();
    b2.req = 1'b0;
    rst = 1'b1;
    chk("rstmid_rvalid_a", b2.rvalid, 0);
    step();
    chk("rstmid_rvalid_b", b2.rvalid, 0);
    chk("rstmid_ready", b2.ready, 0);
    chk("rstmid_busy", b2.busy, 1);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("refill_rvalid", b2.rvalid, 0);
      chk("refill_busy", b2.busy, 1);
    end
    step();
    chk("refill_ready", b2.ready, 1);
    chk("refill_busy_done", b2.busy, 0);
    b2.req = 1'b1; b2.we = 1'b0; b2.addr = 32'h8;
    step();
    b2.req = 1'b0;
    chk("refill_rd_pend", b2.rvalid, 0);
    step();
    chk("refill_rd_rvalid", b2.rvalid, 1);
    chk("refill_rd_data", b2.rdata, 32'h0);
    chk("refill_rd_err", b2.err, 0);
    rd1(32'h8, 32'h0, 1'b0, "refill_rd1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
